// File: rtl/roll_decimator.sv
// Windowed sample reducer: average, max, min or decimate over 2^k accepted
// samples, with k derived from the requested prescaler and latched per window.
module roll_decimator #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 12,
  parameter int MAX_SHIFT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  sample_in,
  input  logic             sample_valid,
  input  logic [15:0]      prescaler,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic [OUT_W-1:0] val_out,
  output logic             val_valid,
  output logic [3:0]       shift_cur
);

  localparam int ACC_W = IN_W + MAX_SHIFT;
  localparam int CNT_W = MAX_SHIFT + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         k_q, k_d;
  logic [1:0]         mode_q, mode_d;
  logic [OUT_W-1:0]   val_out_q, val_out_d;
  logic               val_valid_q, val_valid_d;

  logic [3:0]         k_live;
  logic [3:0]         k_eff;
  logic [1:0]         mode_eff;
  logic               first;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   win_len;
  logic               done;
  logic [IN_W-1:0]    red;
  logic [IN_W-1:0]    held;

  // Smallest k with 2^k >= p, clamped to MAX_SHIFT; p of 0 or 1 yields 0.
  function automatic logic [3:0] k_of(input logic [15:0] p);
    logic [3:0] k;
    k = 4'(MAX_SHIFT);
    for (int i = MAX_SHIFT - 1; i >= 0; i--) begin
      if ({1'b0, p} <= (17'd1 << i)) begin
        k = 4'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

  // Next-state, reduction datapath and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    k_d         = k_q;
    mode_d      = mode_q;
    val_out_d   = val_out_q;
    val_valid_d = 1'b0;

    k_live   = k_of(prescaler);
    first    = (state_q == EMPTY);
    k_eff    = first ? k_live : k_q;
    mode_eff = first ? mode : mode_q;
    held     = acc_q[IN_W-1:0];

    // The first sample of a window is loaded directly, never combined.
    if (first) begin
      acc_next = ACC_W'(sample_in);
    end else begin
      case (mode_eff)
        2'd0:    acc_next = acc_q + ACC_W'(sample_in);
        2'd1:    acc_next = (sample_in > held) ? ACC_W'(sample_in) : acc_q;
        2'd2:    acc_next = (sample_in < held) ? ACC_W'(sample_in) : acc_q;
        2'd3:    acc_next = ACC_W'(sample_in);
        default: acc_next = acc_q;
      endcase
    end

    cnt_next = first ? CNT_W'(1) : (cnt_q + CNT_W'(1));
    win_len  = CNT_W'(1) << k_eff;
    done     = (cnt_next == win_len);

    if (mode_eff == 2'd0) begin
      red = IN_W'(acc_next >> k_eff);
    end else begin
      red = acc_next[IN_W-1:0];
    end

    if (clear) begin
      state_d = EMPTY;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (sample_valid) begin
      k_d    = k_eff;
      mode_d = mode_eff;
      if (done) begin
        state_d     = EMPTY;
        cnt_d       = '0;
        acc_d       = '0;
        val_out_d   = red[IN_W-1 -: OUT_W];
        val_valid_d = 1'b1;
      end else begin
        state_d = FILL;
        cnt_d   = cnt_next;
        acc_d   = acc_next;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      acc_q       <= '0;
      k_q         <= 4'd0;
      mode_q      <= 2'd0;
      val_out_q   <= '0;
      val_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      val_out_q   <= val_out_d;
      val_valid_q <= val_valid_d;
    end
  end

  assign val_out   = val_out_q;
  assign val_valid = val_valid_q;
  assign shift_cur = (state_q == FILL) ? k_q : k_live;

endmodule

// File: tb/tb_roll_decimator.sv
// Directed bench for roll_decimator with hand-computed expectations.
module tb_roll_decimator;

  logic        clk;
  logic        reset;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [15:0] prescaler;
  logic [1:0]  mode;
  logic        clear;
  logic [11:0] val_out;
  logic        val_valid;
  logic [3:0]  shift_cur;

  int checks = 0;
  int errors = 0;
  int pulses;
  int last_pulse;

  roll_decimator dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .prescaler    (prescaler),
    .mode         (mode),
    .clear        (clear),
    .val_out      (val_out),
    .val_valid    (val_valid),
    .shift_cur    (shift_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample for one clock, then sample outputs 1 time unit after the edge.
  task automatic send(input logic [11:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset        = 1'b1;
    sample_in    = 12'd0;
    sample_valid = 1'b0;
    prescaler    = 16'd0;
    mode         = 2'd0;
    clear        = 1'b0;
    #3;
    check("reset_val_out", 32'(val_out), 32'd0);
    check("reset_val_valid", 32'(val_valid), 32'd0);
    check("reset_shift", 32'(shift_cur), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Live k mapping while EMPTY
    prescaler = 16'd5;     #1; check("k_p5", 32'(shift_cur), 32'd3);
    prescaler = 16'd32768; #1; check("k_p32768", 32'(shift_cur), 32'd15);
    prescaler = 16'd65535; #1; check("k_p65535", 32'(shift_cur), 32'd15);
    prescaler = 16'd1;     #1; check("k_p1", 32'(shift_cur), 32'd0);

    // Average of 4
    prescaler = 16'd4;
    mode      = 2'd0;
    send(12'd100); check("avg_v1", 32'(val_valid), 32'd0);
    check("avg_shift_fill", 32'(shift_cur), 32'd2);
    send(12'd200); check("avg_v2", 32'(val_valid), 32'd0);
    send(12'd300); check("avg_v3", 32'(val_valid), 32'd0);
    send(12'd400); check("avg_v4", 32'(val_valid), 32'd1);
    check("avg_out", 32'(val_out), 32'd250);
    idle(1);
    check("avg_pulse_end", 32'(val_valid), 32'd0);
    check("avg_hold", 32'(val_out), 32'd250);

    // Max with gaps; prescaler change mid-window is ignored
    prescaler = 16'd3;
    mode      = 2'd1;
    send(12'd5); idle(2);
    send(12'd4095);
    prescaler = 16'd8;
    #1; check("max_shift_latched", 32'(shift_cur), 32'd2);
    idle(1);
    send(12'd7); check("max_v3", 32'(val_valid), 32'd0);
    idle(3);
    check("max_idle_nopulse", 32'(val_valid), 32'd0);
    send(12'd0); check("max_v4", 32'(val_valid), 32'd1);
    check("max_out", 32'(val_out), 32'd4095);
    check("max_shift_live", 32'(shift_cur), 32'd3);

    // Decimate with k=0, back-to-back pulses
    prescaler    = 16'd1;
    mode         = 2'd3;
    sample_valid = 1'b1;
    sample_in    = 12'd1; @(posedge clk); #1;
    check("dec_v1", 32'(val_valid), 32'd1); check("dec_o1", 32'(val_out), 32'd1);
    sample_in    = 12'd2; @(posedge clk); #1;
    check("dec_v2", 32'(val_valid), 32'd1); check("dec_o2", 32'(val_out), 32'd2);
    sample_in    = 12'd3; @(posedge clk); #1;
    check("dec_v3", 32'(val_valid), 32'd1); check("dec_o3", 32'(val_out), 32'd3);
    sample_valid = 1'b0;
    idle(1);
    check("dec_end", 32'(val_valid), 32'd0);

    // Average truncation: (3+4)>>1 = 3
    prescaler = 16'd2;
    mode      = 2'd0;
    send(12'd3);
    send(12'd4); check("trunc_v", 32'(val_valid), 32'd1);
    check("trunc_out", 32'(val_out), 32'd3);

    // Min with clear aborting the first window; sample alongside clear is dropped
    prescaler = 16'd4;
    mode      = 2'd2;
    send(12'd9);
    send(12'd3);
    clear = 1'b1;
    send(12'd1);
    clear = 1'b0;
    check("clr_nopulse", 32'(val_valid), 32'd0);
    check("clr_out_kept", 32'(val_out), 32'd3);
    send(12'd8); check("min_v1", 32'(val_valid), 32'd0);
    send(12'd6); check("min_v2", 32'(val_valid), 32'd0);
    send(12'd7); check("min_v3", 32'(val_valid), 32'd0);
    send(12'd5); check("min_v4", 32'(val_valid), 32'd1);
    check("min_out", 32'(val_out), 32'd5);

    // Asynchronous reset mid-window
    prescaler = 16'd8;
    mode      = 2'd0;
    for (int i = 0; i < 5; i++) send(12'd1000);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out", 32'(val_out), 32'd0);
    check("areset_valid", 32'(val_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    last_pulse = -1;
    for (int i = 0; i < 8; i++) begin
      send(12'd800);
      if (val_valid) begin
        pulses++;
        last_pulse = i;
      end
    end
    check("areset_pulses", 32'(pulses), 32'd1);
    check("areset_pulse_pos", 32'(last_pulse), 32'd7);
    check("areset_avg", 32'(val_out), 32'd800);

    // Largest window: prescaler clamps to k=15
    prescaler    = 16'd40000;
    mode         = 2'd0;
    pulses       = 0;
    last_pulse   = -1;
    sample_in    = 12'd4095;
    sample_valid = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) check("big_shift", 32'(shift_cur), 32'd15);
      if (val_valid) begin
        pulses++;
        last_pulse = i;
      end
    end
    sample_valid = 1'b0;
    check("big_pulses", 32'(pulses), 32'd1);
    check("big_pulse_pos", 32'(last_pulse), 32'd32767);
    check("big_out", 32'(val_out), 32'd4095);
    idle(1);
    check("big_end", 32'(val_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
